// File: rtl/card_pair_checker.sv
// Memory-game turn controller: takes two card picks, compares their face values,
// keeps a mismatched pair revealed for HOLD_CYCLES cycles and counts completed pairs.
module card_pair_checker #(
  parameter int HOLD_CYCLES = 50,
  parameter int NUM_CARDS   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pick_valid,
  input  logic [7:0]             pick_idx,
  input  logic [3*NUM_CARDS-1:0] board_values,
  input  logic [NUM_CARDS-1:0]   matched_mask,
  output logic [7:0]             selected1,
  output logic [7:0]             selected2,
  output logic                   par,
  output logic                   par_valid,
  output logic                   pick_err,
  output logic                   busy,
  output logic [3:0]             pairs_found,
  output logic                   game_over
);

  localparam int         CW          = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int         TOTAL_PAIRS = NUM_CARDS / 2;
  localparam logic [7:0] MAX_IDX     = 8'(NUM_CARDS);

  typedef enum logic [2:0] {FIRST, SECOND, COMPARE, HOLD, DONE} state_t;

  state_t          state_reg, state_next;
  logic [7:0]      sel1_reg, sel1_next;
  logic [7:0]      sel2_reg, sel2_next;
  logic            par_reg, par_next;
  logic            par_valid_reg, par_valid_next;
  logic            pick_err_reg, pick_err_next;
  logic [3:0]      pairs_reg, pairs_next;
  logic [CW-1:0]   hold_cnt_reg, hold_cnt_next;

  logic [2:0]      card_val [NUM_CARDS];
  logic            pick_matched;
  logic            pick_bad;
  logic [2:0]      val1, val2;
  logic [3:0]      pairs_inc;

  generate
    for (genvar gi = 0; gi < NUM_CARDS; gi++) begin : g_card
      assign card_val[gi] = board_values[3*gi +: 3];
    end
  endgenerate

  // Index decode by comparison keeps out-of-range indices harmless.
  always_comb begin
    pick_matched = 1'b0;
    val1         = '0;
    val2         = '0;
    for (int k = 0; k < NUM_CARDS; k++) begin
      if (pick_idx == 8'(k + 1)) pick_matched = matched_mask[k];
      if (sel1_reg == 8'(k + 1)) val1 = card_val[k];
      if (sel2_reg == 8'(k + 1)) val2 = card_val[k];
    end
    pick_bad  = (pick_idx == 8'd0) || (pick_idx > MAX_IDX) || pick_matched;
    pairs_inc = (pairs_reg < 4'(TOTAL_PAIRS)) ? pairs_reg + 4'd1 : pairs_reg;
  end

  always_comb begin
    state_next     = state_reg;
    sel1_next      = sel1_reg;
    sel2_next      = sel2_reg;
    par_next       = par_reg;
    par_valid_next = 1'b0;
    pick_err_next  = 1'b0;
    pairs_next     = pairs_reg;
    hold_cnt_next  = hold_cnt_reg;
    case (state_reg)
      FIRST: begin
        if (pick_valid) begin
          if (pick_bad) begin
            pick_err_next = 1'b1;
          end else begin
            sel1_next  = pick_idx;
            sel2_next  = 8'd0;
            par_next   = 1'b0;
            state_next = SECOND;
          end
        end
      end
      SECOND: begin
        if (pick_valid) begin
          if (pick_bad || pick_idx == sel1_reg) begin
            pick_err_next = 1'b1;
          end else begin
            sel2_next  = pick_idx;
            state_next = COMPARE;
          end
        end
      end
      COMPARE: begin
        par_valid_next = 1'b1;
        if (val1 == val2) begin
          par_next   = 1'b1;
          pairs_next = pairs_inc;
          state_next = (pairs_inc == 4'(TOTAL_PAIRS)) ? DONE : FIRST;
        end else begin
          par_next      = 1'b0;
          hold_cnt_next = CW'(HOLD_CYCLES - 1);
          state_next    = HOLD;
        end
      end
      HOLD: begin
        if (hold_cnt_reg == '0) begin
          sel1_next  = 8'd0;
          sel2_next  = 8'd0;
          par_next   = 1'b0;
          state_next = FIRST;
        end else begin
          hold_cnt_next = hold_cnt_reg - CW'(1);
        end
      end
      DONE:    state_next = DONE;
      default: state_next = FIRST;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= FIRST;
      sel1_reg      <= 8'd0;
      sel2_reg      <= 8'd0;
      par_reg       <= 1'b0;
      par_valid_reg <= 1'b0;
      pick_err_reg  <= 1'b0;
      pairs_reg     <= 4'd0;
      hold_cnt_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      sel1_reg      <= sel1_next;
      sel2_reg      <= sel2_next;
      par_reg       <= par_next;
      par_valid_reg <= par_valid_next;
      pick_err_reg  <= pick_err_next;
      pairs_reg     <= pairs_next;
      hold_cnt_reg  <= hold_cnt_next;
    end
  end

  assign selected1   = sel1_reg;
  assign selected2   = sel2_reg;
  assign par         = par_reg;
  assign par_valid   = par_valid_reg;
  assign pick_err    = pick_err_reg;
  assign busy        = (state_reg == COMPARE) || (state_reg == HOLD);
  assign pairs_found = pairs_reg;
  assign game_over   = (pairs_reg == 4'(TOTAL_PAIRS));

endmodule
